// File: rtl/fp_normalise_pipe.sv
// fp_normalise_pipe: two-stage IEEE-754 post-normaliser with a valid/ready handshake.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; the default build truncates.

module fp_normalise_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int GRD_W = 3,
   localparam int IN_W = MAN_W + 2 + GRD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [IN_W-1:0]  in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_frac,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_unf
);

   localparam int N_W  = IN_W - 1;
   localparam int X_W  = EXP_W + 2;
   localparam int LZ_W = $clog2(N_W + 1);
   localparam logic [LZ_W-1:0]       LZ_ONE = {{(LZ_W-1){1'b0}}, 1'b1};
   localparam logic signed [X_W-1:0] X_ZERO = {X_W{1'b0}};
   localparam logic signed [X_W-1:0] X_ONE  = {{(X_W-1){1'b0}}, 1'b1};
   localparam logic signed [X_W-1:0] X_MAX  = {2'b00, {EXP_W{1'b1}}};

`ifdef FP_NORM_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   function automatic logic [LZ_W-1:0] lzc(input logic [N_W-1:0] v);
      logic [LZ_W-1:0] n;
      logic            hit;
      n   = {LZ_W{1'b0}};
      hit = 1'b0;
      for (int i = N_W - 1; i >= 0; i--) begin
         if (hit || v[i]) begin
            hit = 1'b1;
         end else begin
            n = n + LZ_ONE;
         end
      end
      return n;
   endfunction

   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_sign_q,  s1_sign_d;
   logic signed [X_W-1:0]   s1_exp_q,   s1_exp_d;
   logic [N_W-1:0]          s1_norm_q,  s1_norm_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_sign_q,  out_sign_d;
   logic [EXP_W-1:0]        out_exp_q,   out_exp_d;
   logic [MAN_W-1:0]        out_frac_q,  out_frac_d;
   logic                    out_zero_q,  out_zero_d;
   logic                    out_ovf_q,   out_ovf_d;
   logic                    out_unf_q,   out_unf_d;

   logic                    s2_adv_s, s1_adv_s;
   logic [N_W-1:0]          m_low_s, norm_s;
   logic [LZ_W-1:0]         lz_s;
   logic signed [X_W-1:0]   exp_in_s, exp_n_s, exp_r_s;
   logic [MAN_W-1:0]        frac_s, frac_r_s;
   logic                    guard_s, rs_s, round_up_s, rc_s;

   assign s2_adv_s = !out_valid_q || out_ready;
   assign s1_adv_s = s2_adv_s || !s1_valid_q;
   assign in_ready = rst_n && s1_adv_s;

   // Stage 1: bring the leading one to the hidden position
   always_comb begin
      m_low_s  = in_mant[N_W-1:0];
      lz_s     = lzc(m_low_s);
      exp_in_s = $signed({2'b00, in_exp});
      if (in_mant[IN_W-1]) begin
         norm_s    = in_mant[IN_W-1:1];
         norm_s[0] = in_mant[1] | in_mant[0];
         exp_n_s   = exp_in_s + X_ONE;
      end else if (in_mant[IN_W-2]) begin
         norm_s  = m_low_s;
         exp_n_s = exp_in_s;
      end else begin
         norm_s  = m_low_s << lz_s;
         exp_n_s = exp_in_s - $signed({{(X_W-LZ_W){1'b0}}, lz_s});
      end
   end

   // Stage 2 datapath plus pipeline next-state; an empty hidden bit after S1 means zero
   always_comb begin
      frac_s     = s1_norm_q[N_W-2:GRD_W];
      guard_s    = s1_norm_q[GRD_W-1];
      rs_s       = |s1_norm_q[GRD_W-2:0];
      round_up_s = ROUND_EN & guard_s & (rs_s | frac_s[0]);
      {rc_s, frac_r_s} = {1'b0, frac_s} + {{MAN_W{1'b0}}, round_up_s};
      exp_r_s    = s1_exp_q + (rc_s ? X_ONE : X_ZERO);

      out_valid_d = out_valid_q;
      out_sign_d  = out_sign_q;
      out_exp_d   = out_exp_q;
      out_frac_d  = out_frac_q;
      out_zero_d  = out_zero_q;
      out_ovf_d   = out_ovf_q;
      out_unf_d   = out_unf_q;
      if (s2_adv_s) begin
         out_valid_d = s1_valid_q;
         out_sign_d  = s1_sign_q;
         out_zero_d  = 1'b0;
         out_ovf_d   = 1'b0;
         out_unf_d   = 1'b0;
         out_exp_d   = {EXP_W{1'b0}};
         out_frac_d  = {MAN_W{1'b0}};
         if (!s1_norm_q[N_W-1]) begin
            out_zero_d = 1'b1;
         end else if (exp_r_s >= X_MAX) begin
            out_exp_d = {EXP_W{1'b1}};
            out_ovf_d = 1'b1;
         end else if (exp_r_s <= X_ZERO) begin
            out_unf_d = 1'b1;
         end else begin
            out_exp_d  = exp_r_s[EXP_W-1:0];
            out_frac_d = frac_r_s;
         end
      end else begin
         out_valid_d = out_valid_q;
      end

      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_norm_d  = s1_norm_q;
      if (s1_adv_s) begin
         s1_valid_d = in_valid;
         s1_sign_d  = in_sign;
         s1_exp_d   = exp_n_s;
         s1_norm_d  = norm_s;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Pipeline registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= X_ZERO;
         s1_norm_q   <= {N_W{1'b0}};
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_exp_q   <= {EXP_W{1'b0}};
         out_frac_q  <= {MAN_W{1'b0}};
         out_zero_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_unf_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_norm_q   <= s1_norm_d;
         out_valid_q <= out_valid_d;
         out_sign_q  <= out_sign_d;
         out_exp_q   <= out_exp_d;
         out_frac_q  <= out_frac_d;
         out_zero_q  <= out_zero_d;
         out_ovf_q   <= out_ovf_d;
         out_unf_q   <= out_unf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sign  = out_sign_q;
   assign out_exp   = out_exp_q;
   assign out_frac  = out_frac_q;
   assign out_zero  = out_zero_q;
   assign out_ovf   = out_ovf_q;
   assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_normalise_pipe.sv
// Scoreboard bench for fp_normalise_pipe: directed vectors, backpressure and mid-stream reset.
// Expected results follow FP_NORM_ROUND_EN the same way the design does.

module tb_fp_normalise_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid, out_ready, out_sign;
   logic [7:0]  out_exp;
   logic [22:0] out_frac;
   logic        out_zero, out_ovf, out_unf;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
      logic        zero;
      logic        ovf;
      logic        unf;
   } res_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] mant;
      res_t        x;
   } vec_t;

   res_t sb[$];
   vec_t vecs[$];
   res_t got_s;
   res_t snap;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   out_idx  = 0;

   fp_normalise_pipe #(.EXP_W(8), .MAN_W(23), .GRD_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
      .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
   );

   always #5 clk = ~clk;

   assign got_s = {out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf};

   function automatic res_t r(input logic s, input logic [7:0] e, input logic [22:0] f,
                              input logic z, input logic o, input logic u);
      res_t t;
      t = {s, e, f, z, o, u};
      return t;
   endfunction

   function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m, input res_t x);
      vec_t t;
      t = {s, e, m, x};
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic send(input vec_t vv);
      int cyc;
      bit done;
      in_sign  = vv.sign;
      in_exp   = vv.exp;
      in_mant  = vv.mant;
      in_valid = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(vv.x);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept, expected accept within 64 cycles");
      end
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (sb.size() > 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (sb.size() > 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   // Monitor: every handshaken output beat is matched against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected no beat", got_s);
         end else begin
            chk($sformatf("result%0d", out_idx), {29'd0, got_s}, {29'd0, sb.pop_front()});
            out_idx++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk(1'b0, 8'd127, 28'h8000000, r(1'b0, 8'd128, 23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd100, 28'h0000008, r(1'b0, 8'd77,  23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd127, 28'h4000000, r(1'b0, 8'd127, 23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b1, 8'd50,  28'h0000000, r(1'b1, 8'd0,   23'h0, 1'b1, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd254, 28'h8000000, r(1'b0, 8'hFF,  23'h0, 1'b0, 1'b1, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd10,  28'h0000008, r(1'b0, 8'd0,   23'h0, 1'b0, 1'b0, 1'b1)));
`ifdef FP_NORM_ROUND_EN
      vecs.push_back(mk(1'b0, 8'd127, 28'h7FFFFFC, r(1'b0, 8'd128, 23'h0, 1'b0, 1'b0, 1'b0)));
`else
      vecs.push_back(mk(1'b0, 8'd127, 28'h7FFFFFC, r(1'b0, 8'd127, 23'h7FFFFF, 1'b0, 1'b0, 1'b0)));
`endif
      vecs.push_back(mk(1'b1, 8'd127, 28'h4000008, r(1'b1, 8'd127, 23'h1, 1'b0, 1'b0, 1'b0)));
`ifdef FP_NORM_ROUND_EN
      vecs.push_back(mk(1'b0, 8'd127, 28'h800000D, r(1'b0, 8'd128, 23'h1, 1'b0, 1'b0, 1'b0)));
`else
      vecs.push_back(mk(1'b0, 8'd127, 28'h800000D, r(1'b0, 8'd128, 23'h0, 1'b0, 1'b0, 1'b0)));
`endif
      vecs.push_back(mk(1'b0, 8'd127, 28'h4000014, r(1'b0, 8'd127, 23'h2, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd24,  28'h0000008, r(1'b0, 8'd1,   23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b1, 8'd23,  28'h0000008, r(1'b1, 8'd0,   23'h0, 1'b0, 1'b0, 1'b1)));
      vecs.push_back(mk(1'b0, 8'd254, 28'h4000000, r(1'b0, 8'd254, 23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd255, 28'h4000000, r(1'b0, 8'hFF,  23'h0, 1'b0, 1'b1, 1'b0)));
`ifdef FP_NORM_ROUND_EN
      vecs.push_back(mk(1'b0, 8'd254, 28'h7FFFFFC, r(1'b0, 8'hFF,  23'h0, 1'b0, 1'b1, 1'b0)));
`else
      vecs.push_back(mk(1'b0, 8'd254, 28'h7FFFFFC, r(1'b0, 8'd254, 23'h7FFFFF, 1'b0, 1'b0, 1'b0)));
`endif
      vecs.push_back(mk(1'b1, 8'd0,   28'h8000000, r(1'b1, 8'd1,   23'h0, 1'b0, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd255, 28'h0000000, r(1'b0, 8'd0,   23'h0, 1'b1, 1'b0, 1'b0)));
      vecs.push_back(mk(1'b0, 8'd127, 28'h0300000, r(1'b0, 8'd122, 23'h400000, 1'b0, 1'b0, 1'b0)));

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'd0;
      in_mant   = 28'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ready_in_reset", {63'd0, in_ready}, 64'd0);
      chk("reset_outputs", {28'd0, out_valid, got_s}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", {63'd0, in_ready}, 64'd1);

      // Two-cycle latency from accept to out_valid
      @(posedge clk);
      #1;
      send(vecs[0]);
      @(negedge clk);
      chk("latency_cycle1_idle", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("latency_cycle2_valid", {63'd0, out_valid}, 64'd1);
      drain();

      // Back-to-back stream of every directed vector
      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i]);
      end
      drain();

      // Backpressure: two beats buffer, third stalls, outputs hold
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(vecs[7]);
      send(vecs[8]);
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      snap = got_s;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d", k), {28'd0, out_valid, got_s}, {28'd0, 1'b1, snap});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(vecs[3]);
      send(vecs[0]);
      drain();

      // Reset mid-stream discards in-flight beats
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[2]);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("ready_in_midreset", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", {63'd0, in_ready}, 64'd1);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
      send(vecs[9]);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_normalise_pipe.md
# fp_normalise_pipe

Parametrised, pipelined floating-point post-normaliser for the IEEE-754 datapath. It sits after the mantissa adder/subtractor and takes a raw sum with carry, hidden and guard bits plus a provisional exponent. It produces a packed-ready normalised exponent and fraction, with zero, overflow and underflow flags. It generalises single-cycle normalisation to any exponent/mantissa width, adds a valid/ready handshake with backpressure, and handles zero, saturation and flush-to-zero explicitly.

## Interface
Parameters:
- `EXP_W`, 8: exponent width.
- `MAN_W`, 23: stored fraction width (hidden bit excluded).
- `GRD_W`, 3: extra low-order bits below the fraction LSB. Bit order is guard, round, then sticky-OR of the rest; minimum 2.
- Derived `IN_W = MAN_W+2+GRD_W`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: **reset is synchronous and active-low**.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts beat this cycle.
- `in_sign` in 1: sign, passed through.
- `in_exp` in EXP_W: provisional biased exponent.
- `in_mant` in IN_W: [IN_W-1] carry, [IN_W-2] hidden, next MAN_W fraction, low GRD_W guard bits.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_sign` out 1, `out_exp` out EXP_W, `out_frac` out MAN_W: normalised result.
- `out_zero`, `out_ovf`, `out_unf` out 1 each: zero result, exponent overflow (saturated), exponent underflow (flushed).

## Operation
- Stage 1 (S1) registers the normalisation step for the accepted beat:
  - Carry set: shift right 1, exp+1; the shifted-out bit ORs into sticky.
  - Hidden set: no shift.
  - Otherwise: count leading zeros `lz` below the hidden position, shift left `lz`, exp−`lz`.
  - Mantissa all zero: mark zero.
- Exponent arithmetic is signed, EXP_W+2 bits wide, with no wrap.
- Stage 2 (S2) applies rounding (see Configuration), then the exponent checks, then drives the output registers.
  - Rounding carry-out of the fraction: frac=0, exp+1, applied before the checks.
  - exp ≥ 2^EXP_W−1: out_exp all ones, frac 0, out_ovf=1.
  - exp ≤ 0: out_exp 0, frac 0, out_unf=1. No subnormals.
  - Zero: exp 0, frac 0, out_zero=1, sign preserved. Zero does not assert out_unf.
- Flags are mutually exclusive. Sign always passes through unchanged.

## Timing
- Latency is 2 cycles from accept (`in_valid && in_ready`) to `out_valid`, with full throughput of 1 beat/cycle.
- S2 advances when `!out_valid || out_ready`. S1 advances when S2 advances or S1 is empty.
- `in_ready = !s1_valid || s1_advance`. It is combinational from registers and `out_ready`, with no path from `in_valid`.
- While `out_valid && !out_ready`, every output holds stable. Two beats buffer; the third stalls with `in_ready`=0.
- Simultaneous accept and drain in the same cycle is lossless. Beat order is preserved.
- Reset:
  - While `rst_n`=0, `in_ready`=0.
  - At the sampling edge, all valids, data outputs and flags go to 0.
  - Reset mid-stream discards in-flight beats.
  - `in_ready`=1 the first cycle after release.

## Configuration
- `FP_NORM_ROUND_EN` defined: round-to-nearest-even.
  - Round up when guard && (round || sticky || LSB).
  - Sticky includes the bit shifted out in the carry case.
- Undefined: truncation. Guard bits are discarded and no rounding carry occurs. Latency is unchanged.

## Test plan
Defaults EXP_W=8, MAN_W=23, GRD_W=3.
- **Carry:** in_mant=28'h8000000, exp=127 -> 2 cycles later out_exp=128, frac=0, no flags.
- **Leading zeros:** in_mant=28'h0000008, exp=100 -> out_exp=77, frac=0. Then in_mant=28'h4000000, exp=127 -> out_exp=127 unchanged.
- **Zero:** in_mant=0, sign=1, exp=50 -> out_zero=1, out_sign=1, exp=0, frac=0.
- **Overflow and underflow:**
  - in_mant=28'h8000000, exp=254 -> out_ovf=1, exp=8'hFF, frac=0.
  - in_mant=28'h0000008, exp=10 -> out_unf=1, exp=0, frac=0.
- **Rounding tie:** in_mant=28'h7FFFFFC, exp=127.
  - With `FP_NORM_ROUND_EN` -> exp=128, frac=0.
  - Without -> exp=127, frac=23'h7FFFFF.
- **Backpressure and reset:** stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after the 2nd accept, outputs hold, all 4 beats emerge in order with no loss. Assert rst_n=0 mid-stream -> out_valid=0 on the next edge, and in-flight beats never appear.
